// File: rtl/tsb_bus_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// BUS_ARB_TURNAROUND_EN adds the TURN state that floats the bus for one cycle between owners.
package tsb_bus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
`ifdef BUS_ARB_TURNAROUND_EN
    StGrant = 2'd1,
    StTurn  = 2'd2
`else
    StGrant = 2'd1
`endif
  } arb_state_e;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tsb_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set request after 'last', wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] winner_idx,
  output logic [N_REQ-1:0] winner_onehot
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    found         = 1'b0;
    winner_idx    = '0;
    winner_onehot = '0;
    w_pos         = '0;
    // The requester at 'last' is scanned last so the previous owner has the lowest priority.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_pos = IDX_W'((32'(last) + k) % N_REQ);
      if (!found && req[w_pos]) begin
        found                = 1'b1;
        winner_idx           = w_pos;
        winner_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tsb_bus_arbiter.sv
// Round-robin arbiter issuing a registered one-hot enable to the shared tri-state bus buffers.
// Define BUS_ARB_TURNAROUND_EN to insert one all-zero grant cycle on every release.
module tsb_bus_arbiter
  import tsb_bus_arb_pkg::*;
#(
  parameter int unsigned  N_REQ    = 4,
  parameter int unsigned  MAX_HOLD = 8,
  localparam int unsigned OwnerW   = idx_width(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [OwnerW-1:0] owner,
  output logic              busy
);

  localparam int unsigned        HoldW    = idx_width(MAX_HOLD);
  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(MAX_HOLD - 1);
  localparam logic [OwnerW-1:0] LastInit = OwnerW'(N_REQ - 1);

  arb_state_e        r_state, w_state_d;
  logic [N_REQ-1:0]  r_grant, w_grant_d;
  logic [OwnerW-1:0] r_owner, w_owner_d;
  logic [OwnerW-1:0] r_last, w_last_d;
  logic              r_busy, w_busy_d;
  logic [HoldW-1:0]  r_hold_cnt, w_hold_d;

  logic              w_found;
  logic [OwnerW-1:0] w_win_idx;
  logic [N_REQ-1:0]  w_win_onehot;
  logic              w_contend;
  logic              w_release;
  logic              w_issue;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (OwnerW)
  ) u_pick (
    .req           (req),
    .last          (r_last),
    .found         (w_found),
    .winner_idx    (w_win_idx),
    .winner_onehot (w_win_onehot)
  );

  assign w_contend = |(req & ~r_grant);
  assign w_release = (r_state == StGrant) &&
                     (!req[r_owner] || ((r_hold_cnt == HoldMax) && w_contend));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_owner    <= '0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
      r_last     <= LastInit;
    end else begin
      r_state    <= w_state_d;
      r_grant    <= w_grant_d;
      r_owner    <= w_owner_d;
      r_busy     <= w_busy_d;
      r_hold_cnt <= w_hold_d;
      r_last     <= w_last_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StGrant: begin
        if (w_release) begin
`ifdef BUS_ARB_TURNAROUND_EN
          w_state_d = StTurn;
`else
          w_state_d = w_found ? StGrant : StIdle;
`endif
        end
      end
      // IDLE and TURN arbitrate identically
      default: w_state_d = w_found ? StGrant : StIdle;
    endcase
  end

  always_comb begin
    w_grant_d = r_grant;
    w_owner_d = r_owner;
    w_busy_d  = r_busy;
    w_last_d  = r_last;
    w_hold_d  = (r_hold_cnt == HoldMax) ? r_hold_cnt : r_hold_cnt + 1'b1;
    w_issue   = 1'b0;
    case (r_state)
      StGrant: begin
`ifdef BUS_ARB_TURNAROUND_EN
        w_issue = 1'b0;
`else
        w_issue = w_release && w_found;
`endif
      end
      default: w_issue = w_found;
    endcase

    if (w_issue) begin
      w_grant_d = w_win_onehot;
      w_owner_d = w_win_idx;
      w_busy_d  = 1'b1;
      w_last_d  = w_win_idx;
      w_hold_d  = '0;
    end else if ((r_state != StGrant) || w_release) begin
      w_grant_d = '0;
      w_owner_d = '0;
      w_busy_d  = 1'b0;
      w_hold_d  = '0;
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_tsb_bus_arbiter.sv
// Self-checking bench for tsb_bus_arbiter: directed literal cases plus randomized traffic
// compared every cycle against a tenure-based behavioural model.
module tb_tsb_bus_arbiter;

  localparam int N = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Model state: current owner (-1 = none), last winner, cycles granted so far.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_ten   = 0;

  always #5 clk = ~clk;

  tsb_bus_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant),
    .owner (owner),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] rot_exp(input int i);
`ifdef BUS_ARB_TURNAROUND_EN
    if (i % 5 == 4) return 4'b0000;
    return 4'(1 << ((i / 5) % 4));
`else
    return 4'(1 << ((i / 4) % 4));
`endif
  endfunction

  // Behavioural model, advanced on each rising edge from the inputs seen there.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_owner = -1;
        m_last  = N - 1;
        m_ten   = 0;
      end else if (m_owner >= 0) begin
        bit others;
        others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
        if (!req[m_owner] || (m_ten >= H && others)) begin
`ifdef BUS_ARB_TURNAROUND_EN
          m_owner = -1;
`else
          m_owner = pick(req, m_last);
          if (m_owner >= 0) begin
            m_last = m_owner;
            m_ten  = 1;
          end
`endif
        end else begin
          m_ten++;
        end
      end else begin
        m_owner = pick(req, m_last);
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_ten  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
      check("model_owner", owner, (m_owner < 0) ? 0 : m_owner);
      check("model_busy", busy, (m_owner >= 0) ? 1 : 0);
      check("onehot0", $onehot0(grant), 1);
    end
  end

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    cmp_en = 1'b1;
    tick();
    check("reset_grant", grant, 0);
    check("reset_owner", owner, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("first_grant", grant, 4'b0001);

    // Rotation with all requesting, starting from the first grant cycle.
`ifdef BUS_ARB_TURNAROUND_EN
    for (int i = 0; i <= 20; i++) begin
`else
    for (int i = 0; i <= 16; i++) begin
`endif
      check("rotation", grant, rot_exp(i));
      tick();
    end

    // Single requester holds indefinitely.
    do_reset();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("single_grant", grant, 4'b0100);
      check("single_owner", owner, 2);
      tick();
    end
    req = 4'b0000;
    tick();
    check("single_drop", grant, 0);

    // Reset mid-grant restarts the scan from requester 0.
    req = 4'b0100;
    tick();
    check("mid_pre", grant, 4'b0100);
    rst_n = 1'b0;
    req   = 4'b1100;
    tick();
    check("mid_reset", grant, 0);
    rst_n = 1'b1;
    tick();
    check("mid_after", grant, 4'b0100);
    check("mid_owner", owner, 2);

    // Voluntary handover.
    do_reset();
    req = 4'b0011;
    tick();
    check("vol_first", grant, 4'b0001);
    req = 4'b0010;
    tick();
`ifdef BUS_ARB_TURNAROUND_EN
    check("vol_gap", grant, 0);
    tick();
`endif
    check("vol_hand", grant, 4'b0010);
    check("vol_owner", owner, 1);

    // Randomized traffic with occasional resets; checked by the model process.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
